// File: rtl/branch_history_table.sv
// branch_history_table
//   Storage and lookup stage for a 2-bit branch predictor. The table is
//   direct mapped and indexed by PC. Each entry holds a valid bit, a tag,
//   a 2-bit saturating state and a branch target.
//
// Ports
//   clk_i, rst_n_i     clock and asynchronous active-low reset
//   desactivar_bp_i    predictor disable; its rising edge starts a clear sweep
//   fetch_pc_i         fetch PC -> pred_taken_o / pred_target_o (combinational)
//   upd_*_i            resolved-branch update from execute
//   upd_old_state_o    stored state for upd_pc_i (00 on miss), sent to the
//                      predictor next-state logic
//   upd_new_state_i    next state returned by the predictor, written on update
//   clear_busy_o       high while the clear sweep is running
module branch_history_table #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  desactivar_bp_i,
    input  logic [ADDR_WIDTH-1:0] fetch_pc_i,
    output logic                  pred_taken_o,
    output logic [ADDR_WIDTH-1:0] pred_target_o,
    input  logic                  upd_valid_i,
    input  logic [ADDR_WIDTH-1:0] upd_pc_i,
    input  logic                  upd_taken_i,
    input  logic [ADDR_WIDTH-1:0] upd_target_i,
    output logic [1:0]            upd_old_state_o,
    input  logic [1:0]            upd_new_state_i,
    output logic                  clear_busy_o
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic {IDLE, CLEAR} fsm_t;

    logic                  valid   [ENTRIES];
    logic [TAG_W-1:0]      tag_mem [ENTRIES];
    logic [1:0]            ctr     [ENTRIES];
    logic [ADDR_WIDTH-1:0] tgt     [ENTRIES];

    fsm_t                  fsm_q, fsm_d;
    logic                  dis_q;
    logic [INDEX_BITS-1:0] ptr_q;

    logic [INDEX_BITS-1:0] f_idx, u_idx;
    logic [TAG_W-1:0]      f_tag, u_tag;
    logic                  f_hit, u_hit, dis_rise, wr_en;

    assign f_idx = fetch_pc_i[INDEX_BITS+1:2];
    assign f_tag = fetch_pc_i[ADDR_WIDTH-1:INDEX_BITS+2];
    assign u_idx = upd_pc_i[INDEX_BITS+1:2];
    assign u_tag = upd_pc_i[ADDR_WIDTH-1:INDEX_BITS+2];

    assign f_hit = valid[f_idx] && (tag_mem[f_idx] == f_tag);
    assign u_hit = valid[u_idx] && (tag_mem[u_idx] == u_tag);

    assign dis_rise     = desactivar_bp_i && !dis_q;
    assign clear_busy_o = (fsm_q == CLEAR);

    // Sweep and update never write in the same cycle: writes are blocked while busy.
    assign wr_en = upd_valid_i && !desactivar_bp_i && !clear_busy_o;

    assign pred_taken_o    = f_hit && ctr[f_idx][1] && !desactivar_bp_i && !clear_busy_o;
    assign pred_target_o   = pred_taken_o ? tgt[f_idx] : fetch_pc_i + ADDR_WIDTH'(4);
    assign upd_old_state_o = u_hit ? ctr[u_idx] : 2'b00;

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:  if (dis_rise) fsm_d = CLEAR;
            CLEAR: if (!dis_rise && ptr_q == INDEX_BITS'(ENTRIES - 1)) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm_q <= IDLE;
            dis_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            dis_q <= desactivar_bp_i;
            // A new rising edge restarts the sweep from entry 0, even mid-sweep.
            if (dis_rise)
                ptr_q <= '0;
            else if (fsm_q == CLEAR)
                ptr_q <= ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                tag_mem[i] <= '0;
                ctr[i]     <= 2'b00;
                tgt[i]     <= '0;
            end
        end else if (fsm_q == CLEAR) begin
            valid[ptr_q] <= 1'b0;
            ctr[ptr_q]   <= 2'b00;
        end else if (wr_en) begin
            if (u_hit) begin
                ctr[u_idx] <= upd_new_state_i;
                if (upd_taken_i)
                    tgt[u_idx] <= upd_target_i;
            end else if (upd_taken_i) begin
                // Only taken branches allocate; not-taken misses leave the table alone.
                valid[u_idx]   <= 1'b1;
                tag_mem[u_idx] <= u_tag;
                tgt[u_idx]     <= upd_target_i;
                ctr[u_idx]     <= upd_new_state_i;
            end
        end
    end
endmodule

// File: tb/tb_branch_history_table.sv
module tb_branch_history_table;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        desactivar_bp_i = 1'b0;
    logic [31:0] fetch_pc_i = 32'h0;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = 32'h0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = 32'h0;
    logic [1:0]  upd_old_state_o;
    logic [1:0]  upd_new_state_i = 2'b00;
    logic        clear_busy_o;

    branch_history_table #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .desactivar_bp_i(desactivar_bp_i),
        .fetch_pc_i(fetch_pc_i), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .upd_old_state_o(upd_old_state_o),
        .upd_new_state_i(upd_new_state_i), .clear_busy_o(clear_busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum {S_TAKEN, S_TARGET, S_OLD, S_BUSY} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input sel_t sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic exp_fetch(input string tag, input logic taken, input logic [31:0] target);
        push_exp({tag, "_taken"}, S_TAKEN, {31'b0, taken});
        push_exp({tag, "_target"}, S_TARGET, target);
    endtask

    task automatic check_pending();
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_TAKEN:  act = {31'b0, pred_taken_o};
                S_TARGET: act = pred_target_o;
                S_OLD:    act = {30'b0, upd_old_state_o};
                default:  act = {31'b0, clear_busy_o};
            endcase
            chk(e.tag, act, e.exp);
        end
    endtask

    // Compare everything queued for this cycle on the falling edge, then step past the next rising edge.
    task automatic tick();
        @(negedge clk_i);
        check_pending();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tg, input logic [1:0] ns);
        upd_valid_i = v; upd_pc_i = pc; upd_taken_i = tk; upd_target_i = tg; upd_new_state_i = ns;
    endtask

    initial begin
        // Reset values
        fetch_pc_i = 32'h100;
        set_upd(1'b0, 32'h100, 1'b0, 32'h0, 2'b00);
        #3;
        exp_fetch("rst", 1'b0, 32'h104);
        push_exp("rst_old", S_OLD, 32'h0);
        push_exp("rst_busy", S_BUSY, 32'h0);
        check_pending();
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        // Train 0x100: allocate with 01, then 01 -> 10 with a same-cycle fetch
        set_upd(1'b1, 32'h100, 1'b1, 32'h200, 2'b01);
        exp_fetch("alloc_cyc", 1'b0, 32'h104);
        push_exp("alloc_cyc_old", S_OLD, 32'h0);
        tick();
        set_upd(1'b0, 32'h100, 1'b0, 32'h0, 2'b00);
        exp_fetch("after_alloc", 1'b0, 32'h104);
        push_exp("after_alloc_old", S_OLD, 32'h1);
        tick();
        set_upd(1'b1, 32'h100, 1'b1, 32'h200, 2'b10);
        exp_fetch("same_cyc", 1'b0, 32'h104);
        tick();
        set_upd(1'b0, 32'h100, 1'b0, 32'h0, 2'b00);
        exp_fetch("trained", 1'b1, 32'h200);
        push_exp("trained_old", S_OLD, 32'h2);
        tick();

        // Aliasing: same index, different tag
        fetch_pc_i = 32'h200;
        upd_pc_i   = 32'h200;
        exp_fetch("alias", 1'b0, 32'h204);
        push_exp("alias_old", S_OLD, 32'h0);
        tick();

        // Not-taken miss must not allocate
        set_upd(1'b1, 32'h300, 1'b0, 32'h700, 2'b01);
        tick();
        set_upd(1'b0, 32'h300, 1'b0, 32'h0, 2'b00);
        fetch_pc_i = 32'h300;
        exp_fetch("nt_miss", 1'b0, 32'h304);
        push_exp("nt_miss_old", S_OLD, 32'h0);
        tick();
        upd_pc_i = 32'h100;
        push_exp("nt_keep_old", S_OLD, 32'h2);
        tick();

        // Second entry 0x104 straight to 11
        set_upd(1'b1, 32'h104, 1'b1, 32'h400, 2'b11);
        tick();
        set_upd(1'b0, 32'h100, 1'b0, 32'h0, 2'b00);
        fetch_pc_i = 32'h104;
        exp_fetch("e1", 1'b1, 32'h400);
        tick();

        // Disable pulse: gated prediction in the pulse cycle, then 64-cycle sweep
        fetch_pc_i = 32'h100;
        desactivar_bp_i = 1'b1;
        exp_fetch("dis_cyc", 1'b0, 32'h104);
        push_exp("dis_cyc_busy", S_BUSY, 32'h0);
        tick();
        desactivar_bp_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 10) set_upd(1'b1, 32'h108, 1'b1, 32'h500, 2'b11);
            else         set_upd(1'b0, 32'h100, 1'b0, 32'h0, 2'b00);
            push_exp($sformatf("sweep_busy_%0d", i), S_BUSY, 32'h1);
            if (i == 0) begin
                push_exp("sweep_taken0", S_TAKEN, 32'h0);
                push_exp("sweep_old0", S_OLD, 32'h2);
            end
            tick();
        end
        set_upd(1'b0, 32'h100, 1'b0, 32'h0, 2'b00);
        push_exp("sweep_done_busy", S_BUSY, 32'h0);
        exp_fetch("post_sweep", 1'b0, 32'h104);
        push_exp("post_sweep_old100", S_OLD, 32'h0);
        tick();
        upd_pc_i = 32'h104; fetch_pc_i = 32'h104;
        exp_fetch("post_sweep104", 1'b0, 32'h108);
        push_exp("post_sweep_old104", S_OLD, 32'h0);
        tick();
        upd_pc_i = 32'h108;
        push_exp("sweep_drop_old", S_OLD, 32'h0);
        tick();

        // Disable held past the sweep: updates dropped
        fetch_pc_i = 32'h100;
        set_upd(1'b1, 32'h100, 1'b1, 32'h200, 2'b10);
        tick();
        set_upd(1'b0, 32'h100, 1'b0, 32'h0, 2'b00);
        exp_fetch("retrain", 1'b1, 32'h200);
        tick();
        desactivar_bp_i = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) tick();
        push_exp("held_busy", S_BUSY, 32'h0);
        exp_fetch("held", 1'b0, 32'h104);
        set_upd(1'b1, 32'h10C, 1'b1, 32'h600, 2'b11);
        tick();
        set_upd(1'b0, 32'h10C, 1'b0, 32'h0, 2'b00);
        desactivar_bp_i = 1'b0;
        fetch_pc_i = 32'h10C;
        push_exp("held_drop_old", S_OLD, 32'h0);
        exp_fetch("held_drop", 1'b0, 32'h110);
        tick();

        // Reset in the middle of a sweep
        set_upd(1'b1, 32'h1FC, 1'b1, 32'h800, 2'b10);
        tick();
        set_upd(1'b0, 32'h1FC, 1'b0, 32'h0, 2'b00);
        fetch_pc_i = 32'h1FC;
        exp_fetch("pre_rst", 1'b1, 32'h800);
        tick();
        desactivar_bp_i = 1'b1;
        tick();
        desactivar_bp_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        push_exp("mid_busy", S_BUSY, 32'h1);
        check_pending();
        rst_n_i = 1'b0;
        #1;
        push_exp("rst_mid_busy", S_BUSY, 32'h0);
        push_exp("rst_mid_old", S_OLD, 32'h0);
        exp_fetch("rst_mid", 1'b0, 32'h200);
        check_pending();
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        push_exp("rst_rel_busy", S_BUSY, 32'h0);
        exp_fetch("rst_rel", 1'b0, 32'h200);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
